// File: rtl/risc_v_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : risc_v_fetch_queue
// Purpose  : Instruction fetch queue. A slot is allocated and tagged with its
//            PC when a fetch request is accepted. The slot is filled when its
//            in-order response returns. The head slot is presented to decode.
//            A redirect frees every slot. Responses still outstanding at that
//            point are counted and dropped when they arrive.
// Options  : define RISC_V_FQ_PERF_EN to add the FLUSH_CNT/DISCARD_CNT counters
// Revision : 1.0 - initial release
// ============================================================================
module risc_v_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrc,
  input  logic [XLEN-1:0]          PC_Branch,
  input  logic                     IF_ID_write,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     VALID_ID,
  output logic [XLEN-1:0]          PC_ID,
  output logic [31:0]              INSTRUCTION_ID,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
`ifdef RISC_V_FQ_PERF_EN
  ,
  output logic [31:0]              FLUSH_CNT,
  output logic [31:0]              DISCARD_CNT
`endif
);

  localparam int               c_PTR_W  = $clog2(DEPTH);
  localparam int               c_CNT_W  = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [31:0]      c_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0]  c_PC_INC = XLEN'(4);

  // Queue bookkeeping: the head index, the number of allocated slots, and the
  // number of filled slots. Filled slots are always the oldest ones, because
  // responses return in order.
  logic [XLEN-1:0]    r_fetch_pc;
  logic [c_PTR_W-1:0] r_head;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_filled;
  logic [c_CNT_W-1:0] r_drop;
  logic [XLEN-1:0]    r_slot_pc  [DEPTH];
  logic [31:0]        r_slot_ins [DEPTH];

  logic [c_CNT_W-1:0] w_pending;
  logic [c_CNT_W-1:0] w_inflight;
  logic               w_req;
  logic               w_alloc;
  logic               w_valid;
  logic               w_pop;
  logic               w_resp_live;
  logic               w_discard;
  logic               w_fill;
  logic [c_PTR_W-1:0] w_tail;
  logic [c_PTR_W-1:0] w_fill_idx;
  logic [c_CNT_W-1:0] w_alloc_x;
  logic [c_CNT_W-1:0] w_pop_x;
  logic [c_CNT_W-1:0] w_fill_x;
  logic [c_CNT_W-1:0] w_discard_x;

  // Requests that are accepted but have not returned yet. This counts both
  // live slots and requests that are waiting to be dropped. The total never
  // exceeds DEPTH, so it fits in the count width.
  assign w_pending   = r_count - r_filled;
  assign w_inflight  = w_pending + r_drop;

  // The reset term keeps the request low while reset is asserted, whatever
  // PCSrc does.
  assign w_req       = reset && !PCSrc && (r_count < c_DEPTH) && (w_inflight < c_DEPTH);
  assign w_alloc     = w_req && imem_ready;
  assign w_valid     = (r_filled != '0);
  assign w_pop       = w_valid && IF_ID_write && !PCSrc;

  // A response with nothing outstanding is stray and is ignored.
  assign w_resp_live = imem_rvalid && (w_inflight != '0);

  // A response is dropped when older redirects still have drops owed. It is
  // also dropped when it arrives on the same edge as a redirect.
  assign w_discard   = w_resp_live && ((r_drop != '0) || PCSrc);
  assign w_fill      = w_resp_live && !w_discard;

  assign w_tail      = r_head + r_count[c_PTR_W-1:0];
  assign w_fill_idx  = r_head + r_filled[c_PTR_W-1:0];

  assign w_alloc_x   = {{(c_CNT_W-1){1'b0}}, w_alloc};
  assign w_pop_x     = {{(c_CNT_W-1){1'b0}}, w_pop};
  assign w_fill_x    = {{(c_CNT_W-1){1'b0}}, w_fill};
  assign w_discard_x = {{(c_CNT_W-1){1'b0}}, w_discard};

  // Update the fetch PC, the queue pointers and the drop count. A redirect
  // takes priority over a pop on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= PC_RESET;
      r_head     <= '0;
      r_count    <= '0;
      r_filled   <= '0;
      r_drop     <= '0;
    end else if (PCSrc) begin
      r_fetch_pc <= PC_Branch;
      r_count    <= '0;
      r_filled   <= '0;
      r_drop     <= w_inflight - w_discard_x;
    end else begin
      if (w_alloc) begin
        r_fetch_pc <= r_fetch_pc + c_PC_INC;
      end
      r_head   <= r_head + w_pop_x[c_PTR_W-1:0];
      r_count  <= r_count + w_alloc_x - w_pop_x;
      r_filled <= r_filled + w_fill_x - w_pop_x;
      if (w_discard) begin
        r_drop <= r_drop - 1'b1;
      end
    end
  end

  // Slot storage: the PC is written at allocation and the instruction is
  // written at fill. Both writes are disabled during a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot_pc[i]  <= '0;
        r_slot_ins[i] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_slot_pc[w_tail] <= r_fetch_pc;
      end
      if (w_fill) begin
        r_slot_ins[w_fill_idx] <= imem_rdata;
      end
    end
  end

`ifdef RISC_V_FQ_PERF_EN
  // Event counters for redirects and dropped responses. Both wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FLUSH_CNT   <= '0;
      DISCARD_CNT <= '0;
    end else begin
      if (PCSrc) begin
        FLUSH_CNT <= FLUSH_CNT + 32'd1;
      end
      if (w_discard) begin
        DISCARD_CNT <= DISCARD_CNT + 32'd1;
      end
    end
  end
`endif

  // With the queue empty, the head slot would be the next allocation. So
  // PC_ID shows the current fetch PC in that case.
  assign imem_req       = w_req;
  assign imem_addr      = r_fetch_pc;
  assign VALID_ID       = w_valid;
  assign PC_ID          = (r_count != '0) ? r_slot_pc[r_head] : r_fetch_pc;
  assign INSTRUCTION_ID = w_valid ? r_slot_ins[r_head] : c_NOP;
  assign OCCUPANCY      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_risc_v_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_v_fetch_queue
// Purpose  : Self-checking bench for risc_v_fetch_queue. A queue-level
//            reference model and an in-order memory responder are driven by
//            directed and random stimulus.
// Options  : RISC_V_FQ_PERF_EN also checks FLUSH_CNT/DISCARD_CNT
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_v_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PC_Branch;
  logic        IF_ID_write;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req,   w_imem_req;
  logic [31:0] imem_addr,  w_imem_addr;
  logic        VALID_ID,   w_VALID_ID;
  logic [31:0] PC_ID,      w_PC_ID;
  logic [31:0] INSTRUCTION_ID, w_INSTRUCTION_ID;
  logic [2:0]  OCCUPANCY,  w_OCCUPANCY;
`ifdef RISC_V_FQ_PERF_EN
  logic [31:0] FLUSH_CNT, DISCARD_CNT, w_FLUSH_CNT, w_DISCARD_CNT;
`endif

  risc_v_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_Branch(PC_Branch),
    .IF_ID_write(IF_ID_write), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .VALID_ID(VALID_ID), .PC_ID(PC_ID), .INSTRUCTION_ID(INSTRUCTION_ID),
    .OCCUPANCY(OCCUPANCY)
`ifdef RISC_V_FQ_PERF_EN
    , .FLUSH_CNT(FLUSH_CNT), .DISCARD_CNT(DISCARD_CNT)
`endif
  );

  // Second copy with a reset PC near the top of the address space to show wrap
  risc_v_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_Branch(PC_Branch),
    .IF_ID_write(IF_ID_write), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .VALID_ID(w_VALID_ID), .PC_ID(w_PC_ID), .INSTRUCTION_ID(w_INSTRUCTION_ID),
    .OCCUPANCY(w_OCCUPANCY)
`ifdef RISC_V_FQ_PERF_EN
    , .FLUSH_CNT(w_FLUSH_CNT), .DISCARD_CNT(w_DISCARD_CNT)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of fetched entries, fetch PC and owed drops
  typedef struct {
    logic [31:0] pc;
    bit          filled;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    logic [31:0] data;
    int          due;
  } mreq_t;

  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_fpc;
  int          m_drop, m_flush, m_discard;
  int          cyc, last_due;

  // Stimulus knobs (percentages and latency range)
  int          p_ready, p_pop, p_flush, p_rvalid, p_spur, lat_min, lat_max;
  bit          rand_br;
  logic [31:0] next_branch;

  // Observations of the most recent cycle
  bit          last_hs;
  logic [31:0] last_addr, last_waddr;

  int n_cmp, n_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    memq.delete();
    m_fpc     = 32'h0;
    m_drop    = 0;
    m_flush   = 0;
    m_discard = 0;
    last_due  = 0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance models at posedge
  task automatic do_cycle();
    bit          exp_req, exp_valid, hs, from_mem;
    logic [31:0] exp_pc, exp_ins;
    int          unret;
    mreq_t       r;
    ent_t        e;

    imem_ready  = ($urandom_range(99) < p_ready);
    IF_ID_write = ($urandom_range(99) < p_pop);
    PCSrc       = ($urandom_range(99) < p_flush);
    PC_Branch   = rand_br ? ($urandom & 32'hFFFF_FFFC) : next_branch;
    from_mem    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (memq.size() > 0) begin
      if (memq[0].due <= cyc && $urandom_range(99) < p_rvalid) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memq[0].data;
        from_mem    = 1'b1;
      end
    end else if ($urandom_range(99) < p_spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end
    #1;

    unret = 0;
    foreach (mq[i]) if (!mq[i].filled) unret++;
    exp_req   = !PCSrc && (mq.size() < DEPTH) && ((unret + m_drop) < DEPTH);
    exp_valid = (mq.size() > 0) && mq[0].filled;
    exp_pc    = (mq.size() > 0) ? mq[0].pc : m_fpc;
    exp_ins   = exp_valid ? mq[0].data : NOP;
    check("imem_req",       64'(imem_req),       64'(exp_req));
    check("imem_addr",      64'(imem_addr),      64'(m_fpc));
    check("VALID_ID",       64'(VALID_ID),       64'(exp_valid));
    check("PC_ID",          64'(PC_ID),          64'(exp_pc));
    check("INSTRUCTION_ID", 64'(INSTRUCTION_ID), 64'(exp_ins));
    check("OCCUPANCY",      64'(OCCUPANCY),      64'(mq.size()));
`ifdef RISC_V_FQ_PERF_EN
    check("FLUSH_CNT",      64'(FLUSH_CNT),      64'(m_flush));
    check("DISCARD_CNT",    64'(DISCARD_CNT),    64'(m_discard));
`endif
    hs         = exp_req && imem_ready;
    last_hs    = hs;
    last_addr  = imem_addr;
    last_waddr = w_imem_addr;

    @(posedge clk);
    cyc++;
    // Memory side: retire the returned response, then queue the new request
    if (from_mem) void'(memq.pop_front());
    if (hs) begin
      r.data   = $urandom;
      r.due    = cyc + $urandom_range(lat_max, lat_min) - 1;
      if (r.due < last_due) r.due = last_due;
      last_due = r.due;
      memq.push_back(r);
    end
    // Queue model
    if (PCSrc) begin
      int total;
      total = m_drop + unret;
      if (imem_rvalid && total > 0) begin
        total--;
        m_discard++;
      end
      m_drop = total;
      mq.delete();
      m_fpc = PC_Branch;
      m_flush++;
    end else begin
      bit popv;
      popv = (mq.size() > 0) && mq[0].filled && IF_ID_write;
      if (imem_rvalid) begin
        if (m_drop > 0) begin
          m_drop--;
          m_discard++;
        end else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].data   = imem_rdata;
              break;
            end
          end
        end
      end
      if (popv) void'(mq.pop_front());
      if (hs) begin
        e.pc = m_fpc; e.filled = 1'b0; e.data = 32'h0;
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, check that outputs clear without a clock edge, then release
  task automatic pulse_reset();
    PCSrc = 1'b0; IF_ID_write = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #2 reset = 1'b0;
    #1;
    check("rst_imem_req",  64'(imem_req),       64'(0));
    check("rst_imem_addr", 64'(imem_addr),      64'(32'h0));
    check("rst_VALID_ID",  64'(VALID_ID),       64'(0));
    check("rst_OCCUPANCY", 64'(OCCUPANCY),      64'(0));
    check("rst_INSTR",     64'(INSTRUCTION_ID), 64'(NOP));
    check("rst_PC_ID",     64'(PC_ID),          64'(32'h0));
    check("rst_wrap_PC",   64'(w_PC_ID),        64'(32'hFFFF_FFF8));
`ifdef RISC_V_FQ_PERF_EN
    check("rst_FLUSH",     64'(FLUSH_CNT),      64'(0));
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_knobs(input int rdy, input int pop, input int fl, input int rv, input int lmin, input int lmax);
    p_ready = rdy; p_pop = pop; p_flush = fl; p_rvalid = rv; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    bit seen;
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b0; PCSrc = 1'b0; PC_Branch = 32'h0; IF_ID_write = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    p_spur = 0; rand_br = 1'b0; next_branch = 32'h0;
    set_knobs(0, 0, 0, 0, 1, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    pulse_reset();

    // Streaming fetch with 1-cycle latency and decode always accepting
    set_knobs(100, 100, 0, 100, 1, 1);
    do_cycle();
    check("s0_addr", 64'(last_addr), 64'(32'h0));
    check("s0_wrap", 64'(last_waddr), 64'(32'hFFFF_FFF8));
    do_cycle();
    check("s1_addr", 64'(last_addr), 64'(32'h4));
    check("s1_wrap", 64'(last_waddr), 64'(32'hFFFF_FFFC));
    do_cycle();
    check("s2_addr", 64'(last_addr), 64'(32'h8));
    check("s2_wrap", 64'(last_waddr), 64'(32'h0));
    for (int k = 0; k < 6; k++) do_cycle();

    // Decode stalls: queue saturates, then drains in order
    p_pop = 0;
    for (int k = 0; k < 10; k++) do_cycle();
    check("stall_occ", 64'(OCCUPANCY), 64'(4));
    check("stall_req", 64'(imem_req), 64'(0));
    p_pop = 100;
    for (int k = 0; k < 8; k++) do_cycle();

    // Redirect with three requests outstanding
    pulse_reset();
    set_knobs(100, 100, 0, 100, 6, 6);
    for (int k = 0; k < 3; k++) do_cycle();
    set_knobs(0, 100, 100, 100, 1, 1);
    next_branch = 32'h100;
    do_cycle();
    p_flush = 0;
    check("flush_occ", 64'(OCCUPANCY), 64'(0));
    p_ready = 100;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      do_cycle();
      if (VALID_ID) begin
        seen = 1'b1;
        check("flush_first_pc", 64'(PC_ID), 64'(32'h100));
      end
    end
    if (!seen) check("flush_valid_timeout", 64'(0), 64'(1));

    // Memory not ready: address holds, nothing valid
    pulse_reset();
    set_knobs(0, 100, 0, 100, 1, 1);
    for (int k = 0; k < 5; k++) begin
      do_cycle();
      check("nordy_addr",  64'(imem_addr), 64'(32'h0));
      check("nordy_valid", 64'(VALID_ID), 64'(0));
      check("nordy_instr", 64'(INSTRUCTION_ID), 64'(NOP));
    end

    // Two filled entries, then a mid-stream reset
    set_knobs(100, 0, 0, 100, 1, 1);
    for (int k = 0; k < 3; k++) do_cycle();
    check("pre_rst_occ", 64'(OCCUPANCY), 64'(3));
    pulse_reset();

    // Two redirects back to back
    set_knobs(100, 100, 100, 100, 1, 1);
    next_branch = 32'h200;
    do_cycle();
    next_branch = 32'h300;
    do_cycle();
    p_flush = 0;
    do_cycle();
    check("dbl_flush_addr", 64'(last_addr), 64'(32'h300));
`ifdef RISC_V_FQ_PERF_EN
    check("dbl_flush_cnt", 64'(FLUSH_CNT), 64'(2));
`endif

    // Random traffic against the model
    set_knobs(70, 60, 5, 70, 1, 4);
    p_spur  = 10;
    rand_br = 1'b1;
    for (int k = 0; k < 2000; k++) do_cycle();
    pulse_reset();
    for (int k = 0; k < 500; k++) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
